// File: rtl/piso_tx_scheduler.sv
// piso_tx_scheduler: round-robin arbiter feeding a shared MSB-first PISO stage.
module piso_tx_scheduler #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data_in,
    output logic [3:0]         ack,
    output logic               load,
    output logic [1:0]         grant_id,
    output logic               serial_out,
    output logic               serial_valid,
    output logic               frame_start,
    output logic               busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;
    logic [1:0]       state_q, state_d, ptr_q, ptr_d, gid_q, gid_d, win;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [3:0]       cnt_q, cnt_d, gcnt_q, gcnt_d;
    // Search from ptr upward; descending loop lets the nearest pending index win.
    always_comb begin
        win = ptr_q;
        for (int k = 3; k >= 0; k--)
            if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            S_IDLE: if (req != 4'd0) begin
                state_d = S_LOAD;
                gid_d   = win;
                ptr_d   = win + 2'd1;
                sreg_d  = data_in[win*WIDTH +: WIDTH];
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                cnt_d   = 4'(WIDTH - 1);
            end
            S_SHIFT: begin
                sreg_d  = sreg_q << 1;
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q != 4'd0) ? S_SHIFT : (GAP == 0) ? S_IDLE : S_GAP;
                gcnt_d  = 4'((GAP == 0) ? 0 : GAP - 1);
            end
            default: begin
                state_d = (gcnt_q == 4'd0) ? S_IDLE : S_GAP;
                gcnt_d  = (gcnt_q == 4'd0) ? 4'd0 : gcnt_q - 4'd1;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            gid_q   <= 2'd0;
            sreg_q  <= '0;
            cnt_q   <= 4'd0;
            gcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
        end
    end
    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign load         = state_q == S_LOAD;
    assign ack          = load ? (4'd1 << gid_q) : 4'd0;
    assign grant_id     = gid_q;
    assign serial_valid = state_q == S_SHIFT;
    assign serial_out   = serial_valid & sreg_q[WIDTH-1];
    assign frame_start  = serial_valid && (cnt_q == 4'(WIDTH - 1));
    assign busy         = state_q != S_IDLE;
endmodule

// File: tb/tb_piso_tx_scheduler.sv
// tb_piso_tx_scheduler: directed checks of arbitration, framing, gaps and reset.
module tb_piso_tx_scheduler;
    logic        clk, rst;
    logic [3:0]  req, req2, ack, ack2;
    logic [15:0] din, din2;
    logic        load, serial_out, serial_valid, frame_start, busy;
    logic        load2, serial_out2, serial_valid2, frame_start2, busy2;
    logic [1:0]  grant_id, grant_id2;
    int          n_tests, n_fail, cyc;

    piso_tx_scheduler #(.WIDTH(4), .GAP(1)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(din), .ack(ack), .load(load),
        .grant_id(grant_id), .serial_out(serial_out), .serial_valid(serial_valid),
        .frame_start(frame_start), .busy(busy));

    piso_tx_scheduler #(.WIDTH(4), .GAP(0)) dut_g0 (
        .clk(clk), .rst(rst), .req(req2), .data_in(din2), .ack(ack2), .load(load2),
        .grant_id(grant_id2), .serial_out(serial_out2), .serial_valid(serial_valid2),
        .frame_start(frame_start2), .busy(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'd0;
        req2 = 4'd0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic idle_out;
        req = 4'd0;
        req2 = 4'd0;
        repeat (12) tick;
    endtask

    task automatic wait_load(output logic [1:0] g, output bit ok);
        ok = 1'b0;
        g = 2'd0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick;
            if (load) begin
                ok = 1'b1;
                g = grant_id;
            end
        end
    endtask

    task automatic test_reset;
        logic [10:0] o1, o2;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req = 4'($urandom_range(0, 15));
            req2 = 4'($urandom_range(0, 15));
            din = 16'($urandom);
            din2 = 16'($urandom);
            tick;
            o1 = {ack, load, grant_id, serial_out, serial_valid, frame_start, busy};
            o2 = {ack2, load2, grant_id2, serial_out2, serial_valid2, frame_start2, busy2};
            n_tests++;
            if (o1 !== 11'd0) begin n_fail++; $display("FAIL reset_hold: got %b expected 0", o1); end
            n_tests++;
            if (o2 !== 11'd0) begin n_fail++; $display("FAIL reset_hold_gap0: got %b expected 0", o2); end
        end
        req = 4'b0001;
        req2 = 4'd0;
        rst = 1'b0;
        tick;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL pre_pulse_busy: got %b expected 1", busy); end
        #2 rst = 1'b1;
        #1;
        o1 = {ack, load, grant_id, serial_out, serial_valid, frame_start, busy};
        n_tests++;
        if (o1 !== 11'd0) begin n_fail++; $display("FAIL async_pulse: got %b expected 0", o1); end
        req = 4'b0110;
        #1 rst = 1'b0;
        tick;
        n_tests++;
        if (grant_id !== 2'd1 || ack !== 4'b0010) begin
            n_fail++; $display("FAIL first_grant: got id=%0d ack=%b expected id=1 ack=0010", grant_id, ack);
        end
        idle_out;
    endtask

    task automatic test_single;
        logic [3:0] exp;
        exp = 4'b1101;
        do_reset;
        din = 16'h0000;
        din[3:0] = exp;
        req = 4'b0001;
        tick;
        n_tests++;
        if (ack !== 4'b0001 || load !== 1'b1 || busy !== 1'b1 || serial_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_load: got ack=%b load=%b busy=%b sv=%b expected 0001 1 1 0", ack, load, busy, serial_valid);
        end
        req = 4'd0;
        din = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_tests++;
            if (serial_valid !== 1'b1 || serial_out !== exp[3-i] || frame_start !== (i == 0) ||
                grant_id !== 2'd0 || load !== 1'b0 || ack !== 4'd0) begin
                n_fail++; $display("FAIL single_bit%0d: got sv=%b so=%b fs=%b id=%0d load=%b expected 1 %b %b 0 0",
                                   i, serial_valid, serial_out, frame_start, grant_id, load, exp[3-i], i == 0);
            end
        end
        tick;
        n_tests++;
        if (busy !== 1'b1 || serial_valid !== 1'b0 || serial_out !== 1'b0 || load !== 1'b0) begin
            n_fail++; $display("FAIL single_gap: got busy=%b sv=%b so=%b expected 1 0 0", busy, serial_valid, serial_out);
        end
        tick;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
        idle_out;
    endtask

    task automatic test_round_robin;
        logic [3:0] w[4];
        logic [1:0] order[5];
        logic [3:0] cur;
        int nf, bc, last;
        w = '{4'b1001, 4'b0110, 4'b1110, 4'b0011};
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset;
        din = {w[3], w[2], w[1], w[0]};
        req = 4'b1111;
        nf = 0; bc = 0; last = -1; cur = 4'd0;
        for (int c = 0; c < 60 && nf < 5; c++) begin
            tick;
            if (serial_valid) begin
                if (frame_start) begin
                    n_tests++;
                    if (grant_id !== order[nf]) begin
                        n_fail++; $display("FAIL rr_order%0d: got %0d expected %0d", nf, grant_id, order[nf]);
                    end
                    if (last >= 0) begin
                        n_tests++;
                        if (c - last != 7) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d expected 7", nf, c - last); end
                    end
                    last = c;
                    bc = 0;
                    cur = 4'd0;
                end
                cur = {cur[2:0], serial_out};
                bc++;
                if (bc == 4) begin
                    n_tests++;
                    if (cur !== w[order[nf]]) begin
                        n_fail++; $display("FAIL rr_word%0d: got %b expected %b", nf, cur, w[order[nf]]);
                    end
                    nf++;
                end
            end
        end
        n_tests++;
        if (nf != 5) begin n_fail++; $display("FAIL rr_frames: got %0d expected 5", nf); end
        idle_out;
    endtask

    task automatic test_rr_skip;
        logic [1:0] g;
        bit ok;
        do_reset;
        din = 16'hCA53;
        req = 4'b0100;
        wait_load(g, ok);
        n_tests++;
        if (!ok || g !== 2'd2) begin n_fail++; $display("FAIL skip_g2: got ok=%0d id=%0d expected 1 2", ok, g); end
        req = 4'b1010;
        wait_load(g, ok);
        n_tests++;
        if (!ok || g !== 2'd3) begin n_fail++; $display("FAIL skip_g3: got ok=%0d id=%0d expected 1 3", ok, g); end
        req = 4'b0010;
        wait_load(g, ok);
        n_tests++;
        if (!ok || g !== 2'd1) begin n_fail++; $display("FAIL skip_g1: got ok=%0d id=%0d expected 1 1", ok, g); end
        idle_out;
    endtask

    task automatic test_reset_midframe;
        logic [3:0] exp;
        logic [6:0] o;
        do_reset;
        din = 16'h0000;
        din[3:0] = 4'b1011;
        req = 4'b0001;
        tick;
        req = 4'd0;
        tick;
        tick;
        n_tests++;
        if (serial_valid !== 1'b1 || serial_out !== 1'b0) begin
            n_fail++; $display("FAIL mid_bit2: got sv=%b so=%b expected 1 0", serial_valid, serial_out);
        end
        #2 rst = 1'b1;
        #1;
        o = {serial_out, serial_valid, frame_start, busy, load, grant_id};
        n_tests++;
        if (o !== 7'd0 || ack !== 4'd0) begin n_fail++; $display("FAIL mid_abort: got %b ack=%b expected 0", o, ack); end
        tick;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_hold: got busy=%b expected 0", busy); end
        exp = 4'b0110;
        din[7:4] = exp;
        req = 4'b0010;
        rst = 1'b0;
        tick;
        n_tests++;
        if (grant_id !== 2'd1 || ack !== 4'b0010) begin
            n_fail++; $display("FAIL mid_regrant: got id=%0d ack=%b expected 1 0010", grant_id, ack);
        end
        req = 4'd0;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_tests++;
            if (serial_valid !== 1'b1 || serial_out !== exp[3-i] || grant_id !== 2'd1) begin
                n_fail++; $display("FAIL mid_bit%0d: got sv=%b so=%b id=%0d expected 1 %b 1", i, serial_valid, serial_out, grant_id, exp[3-i]);
            end
        end
        idle_out;
    endtask

    task automatic test_gap0;
        int last, nf;
        do_reset;
        din2 = 16'h000D;
        req2 = 4'b0001;
        last = -1;
        nf = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            n_tests++;
            if (serial_valid2 && load2) begin n_fail++; $display("FAIL gap0_overlap: got sv=1 load=1 expected no overlap"); end
            if (frame_start2) begin
                if (last >= 0) begin
                    n_tests++;
                    if (c - last != 6) begin n_fail++; $display("FAIL gap0_spacing: got %0d expected 6", c - last); end
                end
                last = c;
                nf++;
            end
        end
        n_tests++;
        if (nf < 5) begin n_fail++; $display("FAIL gap0_frames: got %0d expected >=5", nf); end
        idle_out;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        rst = 1'b1;
        req = 4'd0;
        req2 = 4'd0;
        din = 16'd0;
        din2 = 16'd0;
        test_reset;
        test_single;
        test_round_robin;
        test_rr_skip;
        test_reset_midframe;
        test_gap0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
